// File: rtl/axis_pin_src_pkg.sv
// Shared definitions for the pin-sampling AXI4-Stream packetizer.
// Holds parameter defaults, the lane-count helper and the framer state type.
// Optional feature macro used by the top: AXIS_PIN_PACKETIZER_DROP_CNT_EN.
package axis_pin_src_pkg;

    localparam int unsigned PIN_W_DEF     = 8;
    localparam int unsigned WORD_W_DEF    = 32;
    localparam int unsigned FIFO_AW_DEF   = 4;
    localparam int unsigned PKT_LEN_W_DEF = 16;
    localparam int unsigned DROP_CNT_W    = 16;

    // Framer: waiting for the first beat of a packet, or counting beats inside one.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } framer_state_e;

    // Number of pin samples packed into one output word.
    function automatic int unsigned lanes(input int unsigned word_w, input int unsigned pin_w);
        return word_w / pin_w;
    endfunction

endpackage

// File: rtl/axis_pin_src_fifo.sv
// Synchronous first-word-fall-through FIFO with count-based full/empty.
// Ports:
//   aclk, areset     : clock, synchronous active-high reset
//   i_wr_en/i_wr_data: write request (ignored while full)
//   o_full           : registered full flag
//   i_rd_en          : pop the head (ignored while empty)
//   o_rd_data        : current head word
//   o_valid          : registered not-empty flag
module axis_pin_src_fifo
    import axis_pin_src_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W_DEF,
    parameter int unsigned AW     = FIFO_AW_DEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_full,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_valid
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_full;
    logic              r_valid;
    logic              w_wr;
    logic              w_rd;

    // Full/empty are judged on the state at the start of the cycle.
    assign w_wr = i_wr_en && !r_full;
    assign w_rd = i_rd_en && r_valid;

    // Occupancy update; simultaneous push and pop leave the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, count and flags; pointers wrap naturally at DEPTH.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_valid <= (w_count_next != '0);
        end
    end

    // Storage array, not reset.
    always_ff @(posedge aclk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_valid   = r_valid;

endmodule

// File: rtl/axis_pin_packetizer.sv
// Packs PIN_W-wide pin samples into WORD_W words (first sample in the low lane),
// buffers them in a FWFT FIFO and emits them on AXI4-Stream with optional
// fixed-length framing via TLAST.
// Ports:
//   aclk, areset            : clock, synchronous active-high reset
//   data_pins, pins_valid   : sample input, taken when pins_valid is high
//   pkt_len                 : words per packet, 0 = unframed stream
//   m_axis_t*               : AXI4-Stream master (tkeep constant all-ones)
//   drop_count              : saturating dropped-word count
// Macro AXIS_PIN_PACKETIZER_DROP_CNT_EN adds drop_count; without it full-FIFO
// drops happen silently.
module axis_pin_packetizer
    import axis_pin_src_pkg::*;
#(
    parameter int unsigned PIN_W     = PIN_W_DEF,
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned FIFO_AW   = FIFO_AW_DEF,
    parameter int unsigned PKT_LEN_W = PKT_LEN_W_DEF
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [PIN_W-1:0]      data_pins,
    input  logic                  pins_valid,
    input  logic [PKT_LEN_W-1:0]  pkt_len,
    output logic                  m_axis_tvalid,
    output logic [WORD_W-1:0]     m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [WORD_W/8-1:0]   m_axis_tkeep,
    input  logic                  m_axis_tready
`ifdef AXIS_PIN_PACKETIZER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_count
`endif
);

    localparam int unsigned LANES  = lanes(WORD_W, PIN_W);
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    // ---------------- sample assembly ----------------
    logic [LANE_W-1:0] r_lane;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word_full;
    logic              w_word_done;
    logic              w_wr_en;
    logic              w_fifo_full;
    logic              w_fifo_valid;

    assign w_word_done = pins_valid && (r_lane == LANE_W'(LANES - 1));

    // The completing sample goes straight into the written word, no extra cycle.
    always_comb begin
        w_word_full = r_word;
        w_word_full[(LANES-1)*PIN_W +: PIN_W] = data_pins;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (pins_valid) begin
            r_word[r_lane*PIN_W +: PIN_W] <= data_pins;
            r_lane <= w_word_done ? '0 : r_lane + LANE_W'(1);
        end
    end

    // A word completing against a full FIFO is lost; assembly never stalls.
    assign w_wr_en = w_word_done && !w_fifo_full;

    axis_pin_src_fifo #(
        .DATA_W (WORD_W),
        .AW     (FIFO_AW)
    ) u_fifo (
        .aclk      (aclk),
        .areset    (areset),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_word_full),
        .o_full    (w_fifo_full),
        .i_rd_en   (m_axis_tready),
        .o_rd_data (m_axis_tdata),
        .o_valid   (w_fifo_valid)
    );

    // ---------------- framer ----------------
    framer_state_e        r_state;
    framer_state_e        w_state_next;
    logic [PKT_LEN_W-1:0] r_len;
    logic [PKT_LEN_W-1:0] w_len_next;
    logic [PKT_LEN_W-1:0] r_beat;
    logic [PKT_LEN_W-1:0] w_beat_next;
    logic                 r_last_arm;
    logic                 w_last_arm_next;
    logic                 w_hs;

    assign w_hs = w_fifo_valid && m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_beat     <= '0;
            r_last_arm <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_len      <= w_len_next;
            r_beat     <= w_beat_next;
            r_last_arm <= w_last_arm_next;
        end
    end

    // In IDLE r_len tracks pkt_len until a beat is presented, then freezes so
    // tlast stays stable under backpressure; r_last_arm marks the next beat as last.
    always_comb begin
        w_state_next    = r_state;
        w_len_next      = r_len;
        w_beat_next     = r_beat;
        w_last_arm_next = r_last_arm;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    if (r_len > PKT_LEN_W'(1)) begin
                        w_state_next    = ST_IN_PKT;
                        w_beat_next     = PKT_LEN_W'(1);
                        w_last_arm_next = (r_len == PKT_LEN_W'(2));
                    end else begin
                        w_len_next      = pkt_len;
                        w_last_arm_next = (pkt_len == PKT_LEN_W'(1));
                    end
                end else if (!w_fifo_valid) begin
                    w_len_next      = pkt_len;
                    w_last_arm_next = (pkt_len == PKT_LEN_W'(1));
                end
            end
            ST_IN_PKT: begin
                if (w_hs) begin
                    if (r_last_arm) begin
                        w_state_next    = ST_IDLE;
                        w_beat_next     = '0;
                        w_len_next      = pkt_len;
                        w_last_arm_next = (pkt_len == PKT_LEN_W'(1));
                    end else begin
                        w_beat_next     = r_beat + PKT_LEN_W'(1);
                        w_last_arm_next = ((r_beat + PKT_LEN_W'(2)) == r_len);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign m_axis_tvalid = w_fifo_valid;
    assign m_axis_tlast  = r_last_arm && w_fifo_valid;
    assign m_axis_tkeep  = '1;

`ifdef AXIS_PIN_PACKETIZER_DROP_CNT_EN
    // Saturating count of words lost to a full FIFO.
    logic [DROP_CNT_W-1:0] r_drop_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_drop_count <= '0;
        end else if (w_word_done && w_fifo_full && (r_drop_count != '1)) begin
            r_drop_count <= r_drop_count + DROP_CNT_W'(1);
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_axis_pin_packetizer.sv
// Self-checking bench for axis_pin_packetizer (default 8-bit pins, 32-bit words,
// depth-16 FIFO). A queue-based reference model tracks expected words, drops
// and packet framing; a negedge monitor checks every handshake against it.
module tb_axis_pin_packetizer;

    localparam int DEPTH = 16;
    localparam int LANES = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  data_pins = '0;
    logic        pins_valid = 1'b0;
    logic [15:0] pkt_len = '0;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tready = 1'b0;
`ifdef AXIS_PIN_PACKETIZER_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    always #5 aclk = ~aclk;

    axis_pin_packetizer dut (
        .aclk          (aclk),
        .areset        (areset),
        .data_pins     (data_pins),
        .pins_valid    (pins_valid),
        .pkt_len       (pkt_len),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tready (m_axis_tready)
`ifdef AXIS_PIN_PACKETIZER_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] exp_q [$];
    logic [31:0] mdl_word = '0;
    int          mdl_lane = 0;
    int          mdl_drops = 0;
    int          mdl_pushed = 0;
    int          mdl_beat = 0;
    int          mdl_len = 0;

    // Observation state
    int          hs_count = 0;
    int          hs_mark = 0;
    logic [31:0] last_data = '0;
    logic [31:0] last_mask = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    logic [7:0]  s4 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Set inputs for the coming edge and feed accepted samples to the model.
    task automatic drive(input bit v, input logic [7:0] d, input bit rdy);
        pins_valid    = v;
        data_pins     = d;
        m_axis_tready = rdy;
        if (v) begin
            mdl_word[mdl_lane*8 +: 8] = d;
            mdl_lane++;
            if (mdl_lane == LANES) begin
                mdl_lane = 0;
                if (exp_q.size() >= DEPTH) mdl_drops++;
                else begin
                    exp_q.push_back(mdl_word);
                    mdl_pushed++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic cycle(input bit v, input logic [7:0] d, input bit rdy);
        drive(v, d, rdy);
        step();
    endtask

    task automatic mark();
        hs_mark   = hs_count;
        last_mask = '0;
    endtask

    // One monitor sample per cycle, taken at the falling edge.
    task automatic mon_step();
        logic [31:0] exp_w;
        bit          exp_last;
        if (areset) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
            chk("hold_data", m_axis_tdata, prev_data);
            chk("hold_last", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (!m_axis_tvalid) begin
            chk("tlast_idle", 32'(m_axis_tlast), 32'd0);
        end else if (exp_q.size() == 0) begin
            chk("valid_empty", 32'(m_axis_tvalid), 32'd0);
        end else if (m_axis_tready) begin
            exp_w = exp_q.pop_front();
            if (mdl_beat == 0) mdl_len = int'(pkt_len);
            exp_last = (mdl_len != 0) && (mdl_beat + 1 == mdl_len);
            chk("tdata", m_axis_tdata, exp_w);
            chk("tlast", 32'(m_axis_tlast), 32'(exp_last));
            mdl_beat = (exp_last || mdl_len == 0) ? 0 : mdl_beat + 1;
            if (m_axis_tlast && (hs_count - hs_mark) < 32) last_mask[hs_count - hs_mark] = 1'b1;
            hs_count++;
            last_data = m_axis_tdata;
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        exp_q.delete();
        mdl_lane  = 0;
        mdl_word  = '0;
        mdl_beat  = 0;
        mdl_drops = 0;
        step();
        @(negedge aclk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
        step();
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("post_rst_tlast", 32'(m_axis_tlast), 32'd0);
        step();
    endtask

    // Drain with tready held high, bounded; leftovers show up as count failures.
    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            cycle(1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("drained_tvalid", 32'(m_axis_tvalid), 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit rdy);
        for (int l = 0; l < LANES; l++) cycle(1'b1, w[l*8 +: 8], rdy);
    endtask

    initial begin
        fork
            forever begin
                @(negedge aclk);
                mon_step();
            end
        join_none

        // Reset and constant outputs
        do_reset();
        chk("tkeep", 32'(m_axis_tkeep), 32'h0000000F);

        // Four back-to-back samples, one-cycle output latency
        pkt_len = 16'd0;
        mark();
        cycle(1'b1, 8'h11, 1'b1);
        cycle(1'b1, 8'h22, 1'b1);
        cycle(1'b1, 8'h33, 1'b1);
        drive(1'b1, 8'h44, 1'b1);
        @(negedge aclk);
        chk("t1_valid_early", 32'(m_axis_tvalid), 32'd0);
        step();
        drive(1'b0, 8'h00, 1'b1);
        @(negedge aclk);
        chk("t1_valid", 32'(m_axis_tvalid), 32'd1);
        chk("t1_data", m_axis_tdata, 32'h44332211);
        step();
        drain();
        chk("t1_beats", 32'(hs_count - hs_mark), 32'd1);

        // pins_valid toggling: idle cycles do not advance lanes
        mark();
        for (int i = 0; i < 8; i++) cycle((i % 2) == 0, s4[i/2], 1'b1);
        drain();
        chk("t2_beats", 32'(hs_count - hs_mark), 32'd1);
        chk("t2_data", last_data, 32'hD4C3B2A1);

        // Overflow with tready low: 18 words into 16 entries
        do_reset();
        mark();
        for (int w = 0; w < 18; w++) send_word($urandom, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t3_valid_full", 32'(m_axis_tvalid), 32'd1);
`ifdef AXIS_PIN_PACKETIZER_DROP_CNT_EN
        chk("t3_drop_count", 32'(drop_count), 32'd2);
`endif
        drain();
        chk("t3_beats", 32'(hs_count - hs_mark), 32'd16);

        // pkt_len=3, 7 words: tlast on beats 3 and 6
        do_reset();
        pkt_len = 16'd3;
        cycle(1'b0, 8'h00, 1'b1);
        mark();
        for (int w = 0; w < 7; w++) send_word($urandom, 1'b1);
        drain();
        chk("t4_beats", 32'(hs_count - hs_mark), 32'd7);
        chk("t4_last_mask", last_mask, 32'h00000024);

        // pkt_len changed mid-packet takes effect on the next packet
        do_reset();
        pkt_len = 16'd3;
        cycle(1'b0, 8'h00, 1'b0);
        mark();
        for (int w = 0; w < 7; w++) send_word($urandom, 1'b0);
        for (int i = 0; i < 50; i++) begin
            if ((hs_count - hs_mark) >= 1) break;
            cycle(1'b0, 8'h00, 1'b1);
        end
        pkt_len = 16'd2;
        drain();
        chk("t5_beats", 32'(hs_count - hs_mark), 32'd7);
        chk("t5_last_mask", last_mask, 32'h00000054);

        // Unframed random traffic, 20 words to wrap the pointers
        do_reset();
        pkt_len = 16'd0;
        cycle(1'b0, 8'h00, 1'b1);
        mark();
        begin
            int p0;
            p0 = mdl_pushed;
            for (int i = 0; i < 2000; i++) begin
                if (mdl_pushed - p0 >= 20) break;
                cycle($urandom_range(0, 99) < 70, 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        chk("t6_beats", 32'(hs_count - hs_mark), 32'd20);
        chk("t6_last_mask", last_mask, 32'h00000000);

        // pkt_len=1: every beat is last
        pkt_len = 16'd1;
        cycle(1'b0, 8'h00, 1'b1);
        mark();
        begin
            int p0;
            p0 = mdl_pushed;
            for (int i = 0; i < 1000; i++) begin
                if (mdl_pushed - p0 >= 8) break;
                cycle($urandom_range(0, 99) < 60, 8'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        drain();
        chk("t7_beats", 32'(hs_count - hs_mark), 32'd8);
        chk("t7_last_mask", last_mask, 32'h000000FF);

        // Reset mid-word with three words buffered
        do_reset();
        pkt_len = 16'd0;
        for (int i = 0; i < 14; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t8_valid_before", 32'(m_axis_tvalid), 32'd1);
        do_reset();
        mark();
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("t8_empty", 32'(m_axis_tvalid), 32'd0);
        send_word(32'h04030201, 1'b1);
        drain();
        chk("t8_beats", 32'(hs_count - hs_mark), 32'd1);
        chk("t8_data", last_data, 32'h04030201);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
